// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator with sub-word extract and read-modify-write stores.
// Optional LSU_ERR_CHECK_EN enables misalignment, reserved-size and range error responses.
module lsu_mem_master #(
    parameter int MEM_SIZE_BYTES = 4096,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_we
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_nx;
    logic [1:0]  lane_q, size_q, size_e;
    logic        we_q, uns_q, err_q, acc, err;
    logic [31:0] wdata_q, res_q, ld, mask, merged;
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh;

    assign acc = req_valid && state == IDLE;
`ifdef LSU_ERR_CHECK_EN
    assign size_e = req_size;
    assign err = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
                 req_addr >= ADDR_WIDTH'(MEM_SIZE_BYTES);
`else
    assign size_e = req_size == 2'd3 ? 2'd2 : req_size;
    assign err = 1'b0;
`endif

    assign b = mem_rdata[{lane_q, 3'b000} +: 8];
    assign h = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    assign ld = size_q == 2'd0 ? {{24{~uns_q & b[7]}}, b} :
                size_q == 2'd1 ? {{16{~uns_q & h[15]}}, h} : mem_rdata;
    assign sh = size_q == 2'd0 ? {lane_q, 3'b000} : {lane_q[1], 4'b0000};
    assign mask = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);

    // state register; reset drops any pending request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next state: errors skip memory, aligned word stores skip the read
    always_comb begin
        state_nx = state == IDLE ? (req_valid ? (err ? RESP : (req_we && size_e == 2'd2) ? WR : RD) : IDLE) :
                   state == RD   ? (we_q ? WR : RESP) :
                   state == WR   ? RESP : IDLE;
    end

    // request capture, load result capture and store merge at the end of RD
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            res_q       <= '0;
            mem_wdata   <= '0;
            mem_address <= '0;
        end else begin
            if (acc) begin
                lane_q    <= req_addr[1:0];
                size_q    <= size_e;
                we_q      <= req_we;
                uns_q     <= req_unsigned;
                err_q     <= err;
                wdata_q   <= req_wdata;
                res_q     <= '0;
                mem_wdata <= req_wdata;
                if (!err) mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
            if (state == RD) begin
                if (we_q) mem_wdata <= merged;
                else      res_q     <= ld;
            end
        end
    end

    // outputs decoded from state; write enable exists only in WR
    always_comb begin
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        mem_we     = state == WR;
        resp_rdata = resp_valid ? res_q : 32'd0;
        resp_err   = resp_valid && err_q;
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench for lsu_mem_master with a word memory model.
module tb_lsu_mem_master;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
    logic [31:0] mem [0:1023];

    typedef struct {logic [31:0] d; logic e; int c;} exp_t;
    exp_t q[$];
    exp_t x;
    int checks = 0, errors = 0, cyc = 0, rcnt = 0, exp_rcnt = 0, wcnt = 0, exp_wcnt = 0, exp_l = 0;
    logic [31:0] exp_d = '0, exp_ma = '0, exp_mw = '0;
    logic        exp_e = 1'b0;

    lsu_mem_master dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_address[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_address[11:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && req_valid && req_ready) q.push_back('{exp_d, exp_e, cyc + exp_l});
        if (resp_valid) begin
            rcnt++;
            if (q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
            else begin
                x = q.pop_front();
                chk("rdata", resp_rdata, x.d);
                chk("err", {31'd0, resp_err}, {31'd0, x.e});
                chk("latency", 32'(cyc), 32'(x.c));
            end
        end
        if (mem_we) begin
            wcnt++;
            chk("mem_address", mem_address, exp_ma);
            chk("mem_wdata", mem_wdata, exp_mw);
        end
    end

    task automatic wait_done();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            chk("timeout", q.size(), 32'd0);
            q.delete();
        end
        chk("resp_cnt", rcnt, exp_rcnt);
        chk("we_cnt", wcnt, exp_wcnt);
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] d, input logic e, input int l,
                       input logic [31:0] mw);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        exp_d = d; exp_e = e; exp_l = l; exp_ma = {a[31:2], 2'b00}; exp_mw = mw;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        exp_rcnt++;
        if (we && !e) exp_wcnt++;
        wait_done();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        req(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 32'hDEADBEEF);
        req(0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 32'h0);
        req(1, 2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 2, 32'h80FF7F01);
        req(1, 2, 0, 32'h30, 32'h11223344, 32'h0, 0, 2, 32'h11223344);
        req(1, 2, 0, 32'h40, 32'h55667788, 32'h0, 0, 2, 32'h55667788);

        req(0, 0, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0, 2, 32'h0);
        req(0, 0, 1, 32'h23, 32'h0, 32'h00000080, 0, 2, 32'h0);
        req(0, 1, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0, 2, 32'h0);
        req(0, 1, 1, 32'h20, 32'h0, 32'h00007F01, 0, 2, 32'h0);
        req(0, 0, 0, 32'h20, 32'h0, 32'h00000001, 0, 2, 32'h0);

        req(1, 0, 0, 32'h31, 32'h123456AA, 32'h0, 0, 3, 32'h1122AA44);
        chk("mem_sb", mem[32'h30 >> 2], 32'h1122AA44);
        req(1, 1, 0, 32'h32, 32'hCAFEBEEF, 32'h0, 0, 3, 32'hBEEFAA44);
        chk("mem_sh", mem[32'h30 >> 2], 32'hBEEFAA44);
        req(0, 2, 0, 32'h30, 32'h0, 32'hBEEFAA44, 0, 2, 32'h0);

`ifdef LSU_ERR_CHECK_EN
        req(0, 2, 0, 32'h6, 32'h0, 32'h0, 1, 1, 32'h0);
        req(1, 1, 0, 32'h5, 32'h1234, 32'h0, 1, 1, 32'h0);
        req(0, 3, 0, 32'h20, 32'h0, 32'h0, 1, 1, 32'h0);
        req(0, 2, 0, 32'h1000, 32'h0, 32'h0, 1, 1, 32'h0);
        req(1, 2, 0, 32'h1000, 32'h77777777, 32'h0, 1, 1, 32'h0);
`else
        req(0, 2, 0, 32'h12, 32'h0, 32'hDEADBEEF, 0, 2, 32'h0);
        req(0, 1, 0, 32'h21, 32'h0, 32'h00007F01, 0, 2, 32'h0);
        req(0, 3, 0, 32'h20, 32'h0, 32'h80FF7F01, 0, 2, 32'h0);
`endif

        for (int i = 0; i < 3; i++) begin
            req_we = 1'b0; req_unsigned = i == 1;
            req_size = i == 0 ? 2'd2 : i == 1 ? 2'd0 : 2'd1;
            req_addr = i == 0 ? 32'h10 : i == 1 ? 32'h23 : 32'h22;
            exp_d = i == 0 ? 32'hDEADBEEF : i == 1 ? 32'h00000080 : 32'hFFFF80FF;
            exp_e = 1'b0; exp_l = 2;
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("b2b_busy1", {31'd0, req_ready}, 32'd0);
            req_we = 1'b1; req_size = 2'd0; req_addr = 32'h44; req_wdata = $urandom;
            @(posedge clk); #1;
            chk("b2b_busy2", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            chk("b2b_ready", {31'd0, req_ready}, 32'd1);
            exp_rcnt++;
        end
        req_valid = 1'b0;
        wait_done();

        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h99;
        exp_l = 3; exp_d = 32'h0; exp_e = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn = 1'b0;
        #2;
        chk("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_mem", mem[32'h40 >> 2], 32'h55667788);
        chk("rst_mid_addr", mem_address, 32'd0);
        chk("rst_mid_resp_cnt", rcnt, exp_rcnt);
        chk("rst_mid_we_cnt", wcnt, exp_wcnt);

        req(0, 2, 0, 32'h40, 32'h0, 32'h55667788, 0, 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
